// File: rtl/ctrl_encode_def.sv
// Shared encodings: arbiter FSM states and ALU opcodes.
package ctrl_encode_def;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  localparam int ALUOP_W = 5;

  localparam logic [ALUOP_W-1:0] ALUOP_NOP = 5'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 5'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 5'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 5'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 5'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_XOR = 5'd5;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = 5'd6;
  localparam logic [ALUOP_W-1:0] ALUOP_BEQ = 5'd7;
  localparam logic [ALUOP_W-1:0] ALUOP_BNE = 5'd8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection, round-robin on ties by default.
// Define ALU_ARB_FIXED_PRIO_EN to make requester 1 always win instead.
module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (valid1)
      grant = 2'b10;
    else if (valid0)
      grant = 2'b01;
`else
    // On a tie, the requester that did not win last time goes next.
    if (valid0 && valid1)
      grant = last_grant ? 2'b01 : 2'b10;
    else if (valid0)
      grant = 2'b01;
    else if (valid1)
      grant = 2'b10;
`endif
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: IDLE -> EXEC -> RESP.
// Arbitration policy selectable with ALU_ARB_FIXED_PRIO_EN (see rr_arb2).
module alu_arbiter
  import ctrl_encode_def::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_zero,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_zero,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  arb_state_e        state_reg, state_next;
  logic [DATA_W-1:0] a_reg, b_reg;
  logic [OP_W-1:0]   op_reg;
  logic              owner_reg;
  logic              last_grant_reg;
  logic [DATA_W-1:0] result_reg [2];
  logic              zero_reg   [2];
  logic [1:0]        grant;
  logic              accept;
  logic              owner_resp_ready;

  rr_arb2 u_rr_arb2 (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  assign accept           = (state_reg == ST_IDLE) && (grant != 2'b00);
  assign owner_resp_ready = owner_reg ? resp1_ready : resp0_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (owner_resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= '0;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        result_reg[i] <= '0;
        zero_reg[i]   <= 1'b0;
      end
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg          <= grant[1] ? req1_a  : req0_a;
        b_reg          <= grant[1] ? req1_b  : req0_b;
        op_reg         <= grant[1] ? req1_op : req0_op;
        owner_reg      <= grant[1];
        last_grant_reg <= grant[1];
      end
      if (state_reg == ST_EXEC) begin
        result_reg[owner_reg] <= alu_result;
        zero_reg[owner_reg]   <= alu_zero;
      end
    end
  end

  // Ready is gated by rst_n so no handshake is offered while reset is held.
  assign req0_ready = rst_n && accept && grant[0];
  assign req1_ready = rst_n && accept && grant[1];

  assign alu_a  = (state_reg == ST_EXEC) ? a_reg  : '0;
  assign alu_b  = (state_reg == ST_EXEC) ? b_reg  : '0;
  assign alu_op = (state_reg == ST_EXEC) ? op_reg : OP_W'(ALUOP_NOP);

  assign resp0_valid  = (state_reg == ST_RESP) && !owner_reg;
  assign resp1_valid  = (state_reg == ST_RESP) &&  owner_reg;
  assign resp0_result = result_reg[0];
  assign resp1_result = result_reg[1];
  assign resp0_zero   = zero_reg[0];
  assign resp1_zero   = zero_reg[1];
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with an ALU stub and a transaction-level model.
module tb_alu_arbiter;
  import ctrl_encode_def::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid, resp0_zero, resp1_zero;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_ready, resp1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_op;
  logic        alu_zero;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int last_winner = 1;

  alu_arbiter #(.DATA_W(32), .OP_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_result(resp0_result), .resp0_zero(resp0_zero), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_result(resp1_result), .resp1_zero(resp1_zero), .resp1_ready(resp1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    case (op)
      ALUOP_ADD: return a + b;
      ALUOP_SUB: return a - b;
      ALUOP_AND: return a & b;
      ALUOP_OR:  return a | b;
      ALUOP_XOR: return a ^ b;
      ALUOP_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALUOP_BEQ: return (a == b) ? 32'd1 : 32'd0;
      ALUOP_BNE: return (a != b) ? 32'd1 : 32'd0;
      default:   return 32'd0;
    endcase
  endfunction

  // Zero flag reports a taken branch condition; arithmetic ops leave it clear.
  function automatic logic zero_model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    if (op == ALUOP_BEQ) return a == b;
    if (op == ALUOP_BNE) return a != b;
    return 1'b0;
  endfunction

  always_comb begin
    alu_result = alu_model(alu_a, alu_b, alu_op);
    alu_zero   = zero_model(alu_a, alu_b, alu_op);
  end

  function automatic int model_pick(input bit v0, input bit v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1)  return 0;
    if (v1 && !v0)  return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1;
`else
    return 1 - last_winner;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last_winner = 1;
  endtask

  // One full transaction: offer, accept, execute, hold response for 'hold' cycles.
  task automatic txn(input bit v0, input bit v1,
                     input logic [31:0] a0, input logic [31:0] b0, input logic [4:0] op0,
                     input logic [31:0] a1, input logic [31:0] b1, input logic [4:0] op1,
                     input int hold, input bit poke, output int win);
    logic [31:0] ea, eb, er, got_r;
    logic [4:0]  eop;
    logic        ez, got_v, got_z, oth_v;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    win = model_pick(v0, v1);
    @(negedge clk);
    n_vec++; if (req0_ready !== (win == 0)) begin n_err++; $display("FAIL req0_ready got %0b exp %0b", req0_ready, win == 0); end
    n_vec++; if (req1_ready !== (win == 1)) begin n_err++; $display("FAIL req1_ready got %0b exp %0b", req1_ready, win == 1); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy got %0b exp 0", busy); end
    if (win < 0) begin
      step();
      return;
    end
    last_winner = win;
    ea  = win ? a1 : a0;
    eb  = win ? b1 : b0;
    eop = win ? op1 : op0;
    er  = alu_model(ea, eb, eop);
    ez  = zero_model(ea, eb, eop);
    step();
    // Other requests stay asserted to prove they are ignored outside IDLE.
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_vec++; if ({alu_a, alu_b, alu_op} !== {ea, eb, eop}) begin n_err++; $display("FAIL exec_alu got %h/%h/%0d exp %h/%h/%0d", alu_a, alu_b, alu_op, ea, eb, eop); end
    n_vec++; if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 5'b10000) begin n_err++; $display("FAIL exec_ctrl got %b exp 10000", {busy, req0_ready, req1_ready, resp0_valid, resp1_valid}); end
    step();
    for (int k = 0; k <= hold; k++) begin
      if (win == 0) begin resp0_ready = (k == hold); resp1_ready = poke; end
      else          begin resp1_ready = (k == hold); resp0_ready = poke; end
      @(negedge clk);
      got_v = win ? resp1_valid  : resp0_valid;
      got_r = win ? resp1_result : resp0_result;
      got_z = win ? resp1_zero   : resp0_zero;
      oth_v = win ? resp0_valid  : resp1_valid;
      n_vec++; if ({got_v, oth_v} !== 2'b10) begin n_err++; $display("FAIL resp_valid owner %0d got %b exp 10", win, {got_v, oth_v}); end
      n_vec++; if (got_r !== er) begin n_err++; $display("FAIL resp_result owner %0d got %h exp %h", win, got_r, er); end
      n_vec++; if (got_z !== ez) begin n_err++; $display("FAIL resp_zero owner %0d got %0b exp %0b", win, got_z, ez); end
      n_vec++; if ({busy, req0_ready, req1_ready, alu_op} !== {3'b100, 5'd0}) begin n_err++; $display("FAIL resp_ctrl got %b exp 10000000", {busy, req0_ready, req1_ready, alu_op}); end
      step();
    end
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    $display("txn owner=%0d op=%0d a=%h b=%h result=%h zero=%0b hold=%0d", win, eop, ea, eb, er, ez, hold);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    resp0_ready = 1'b0; resp1_ready = 1'b0;
    step();
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    n_vec++; if ({req0_ready, req1_ready, busy, resp0_valid, resp1_valid} !== 5'b0) begin n_err++; $display("FAIL reset_ctrl got %b exp 00000", {req0_ready, req1_ready, busy, resp0_valid, resp1_valid}); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 69'd0) begin n_err++; $display("FAIL reset_alu got %h exp 0", {alu_a, alu_b, alu_op}); end
    n_vec++; if ({resp0_result, resp1_result, resp0_zero, resp1_zero} !== 66'd0) begin n_err++; $display("FAIL reset_result got %h exp 0", {resp0_result, resp1_result, resp0_zero, resp1_zero}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    rst_n = 1'b1;
    last_winner = 1;
    step();
  endtask

  task automatic test_single();
    int w;
    txn(1, 0, 32'd5, 32'd7, ALUOP_ADD, 32'd0, 32'd0, ALUOP_NOP, 1, 0, w);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_vec++; if ({busy, resp0_valid} !== 2'b00) begin n_err++; $display("FAIL single_done got %b exp 00", {busy, resp0_valid}); end
    n_vec++; if (resp0_result !== 32'd12) begin n_err++; $display("FAIL single_result got %0d exp 12", resp0_result); end
    step();
  endtask

  task automatic test_tie();
    int w;
    do_reset();
    txn(1, 1, 32'd9, 32'd9, ALUOP_SUB, 32'hF0, 32'h0F, ALUOP_AND, 0, 0, w);
    txn(w == 1, w == 0, 32'd9, 32'd9, ALUOP_SUB, 32'hF0, 32'h0F, ALUOP_AND, 0, 0, w);
  endtask

  task automatic test_hold();
    int w;
    txn(0, 1, 32'd0, 32'd0, ALUOP_ADD, 32'd3, 32'd3, ALUOP_BEQ, 5, 1, w);
  endtask

  task automatic test_back_to_back();
    int w;
    for (int i = 0; i < 4; i++)
      txn(1, 1, 32'(i), 32'd10, ALUOP_ADD, 32'd20, 32'(i), ALUOP_SUB, 0, 0, w);
  endtask

  task automatic test_reset_mid();
    int w;
    txn(1, 0, 32'h1234, 32'h1, ALUOP_ADD, 32'd0, 32'd0, ALUOP_NOP, 0, 0, w);
    req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 32'd1; req0_b = 32'd2; req0_op = ALUOP_ADD;
    step();
    req0_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({busy, req0_ready, req1_ready, resp0_valid, resp1_valid} !== 5'b0) begin n_err++; $display("FAIL midreset_ctrl got %b exp 00000", {busy, req0_ready, req1_ready, resp0_valid, resp1_valid}); end
    n_vec++; if ({alu_a, alu_b, alu_op} !== 69'd0) begin n_err++; $display("FAIL midreset_alu got %h exp 0", {alu_a, alu_b, alu_op}); end
    n_vec++; if (resp0_result !== 32'd0) begin n_err++; $display("FAIL midreset_result got %h exp 0", resp0_result); end
    step();
    step();
    rst_n = 1'b1;
    last_winner = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++; if ({busy, resp0_valid, resp1_valid} !== 3'b000) begin n_err++; $display("FAIL postreset_idle got %b exp 000", {busy, resp0_valid, resp1_valid}); end
      step();
    end
    txn(1, 1, 32'd4, 32'd4, ALUOP_XOR, 32'd8, 32'd1, ALUOP_OR, 0, 0, w);
  endtask

  task automatic test_random();
    logic [4:0]  ops [8];
    logic [31:0] a0, b0, a1, b1;
    int w;
    ops = '{ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR, ALUOP_XOR, ALUOP_SLT, ALUOP_BEQ, ALUOP_BNE};
    for (int i = 0; i < 40; i++) begin
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 1) == 1) ? a0 : $urandom;
      b1 = ($urandom_range(0, 1) == 1) ? a1 : $urandom;
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          a0, b0, ops[$urandom_range(0, 7)], a1, b1, ops[$urandom_range(0, 7)],
          $urandom_range(0, 3), 1'($urandom_range(0, 1)), w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
